// File: rtl/fft_pkg.sv
// Shared FFT datapath definitions: widths, product-phase encoding and the
// Q30->Q15 round/saturate helper used by every butterfly-side stage.
package fft_pkg;

    localparam int DW   = 16;
    localparam int PW   = 32;
    localparam int FRAC = 15;
    localparam int AW   = PW + 1;

    localparam logic signed [AW-1:0] RND_HALF = AW'(2 ** (FRAC - 1));
    localparam logic signed [AW-1:0] SAT_MAX  = AW'(2 ** (DW - 1) - 1);
    localparam logic signed [AW-1:0] SAT_MIN  = AW'(-(2 ** (DW - 1)));

    typedef enum logic [1:0] {
        PH_AC = 2'd0,
        PH_BD = 2'd1,
        PH_AD = 2'd2,
        PH_BC = 2'd3
    } phase_e;

    typedef struct packed {
        logic [DW-1:0] re;
        logic [DW-1:0] im;
    } cplx_t;

    typedef struct packed {
        logic [DW-1:0] val;
        logic          clamp;
    } sat_rnd_t;

    // Round-half-up then clamp to DW bits; clamp flags any saturation.
    function automatic sat_rnd_t sat_round(input logic signed [AW-1:0] acc);
        logic signed [AW-1:0] r;
        sat_rnd_t             res;
        r = (acc + RND_HALF) >>> FRAC;
        res.clamp = 1'b0;
        if (r > SAT_MAX) begin
            res.val   = SAT_MAX[DW-1:0];
            res.clamp = 1'b1;
        end else if (r < SAT_MIN) begin
            res.val   = SAT_MIN[DW-1:0];
            res.clamp = 1'b1;
        end else begin
            res.val = r[DW-1:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/cplx_fifo.sv
// Small in-order FIFO for complex samples. Entry 0 is always the head, so the
// output is taken straight from a register and holds while not popped.
module cplx_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 2
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_clr,
    input  logic         i_push,
    input  logic [W-1:0] i_din,
    input  logic         i_ready,
    output logic [W-1:0] o_dout,
    output logic         o_full,
    output logic         o_empty
);

    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  r_mem [DEPTH];
    logic [CW-1:0] r_count;
    logic [CW-1:0] w_wr_idx;
    logic          w_pop;
    logic          w_wr;

    assign o_full   = (r_count == CW'(DEPTH));
    assign o_empty  = (r_count == '0);
    assign w_pop    = i_ready && !o_empty;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign w_wr     = i_push && (!o_full || w_pop);
    assign w_wr_idx = w_pop ? (r_count - 1'b1) : r_count;
    assign o_dout   = r_mem[0];

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else begin
            // Keep the last head visible once the FIFO drains.
            if (w_pop && (r_count > CW'(1))) begin
                for (int i = 0; i < DEPTH - 1; i++) r_mem[i] <= r_mem[i+1];
            end
            if (w_wr) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (CW'(i) == w_wr_idx) r_mem[i] <= i_din;
                end
            end
            r_count <= r_count + CW'(w_wr) - CW'(w_pop);
        end
    end

endmodule

// File: rtl/twiddle_prod_combine.sv
// Combines the four serial partial products of (a+jb)(c+jd) into a rounded,
// saturated Q15 complex result and queues it for the next butterfly stage.
module twiddle_prod_combine
    import fft_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_clr,
    input  logic signed [PW-1:0] i_prod_in,
    input  logic                 i_prod_valid,
    output logic        [DW-1:0] o_y_re,
    output logic        [DW-1:0] o_y_im,
    output logic                 o_y_valid,
    input  logic                 i_y_ready,
    output logic [1:0]           o_phase,
    output logic                 o_sat,
    output logic                 o_ovf
);

    phase_e               r_phase;
    phase_e               w_phase_nxt;
    logic signed [AW-1:0] r_acc_re;
    logic signed [AW-1:0] r_acc_im;
    logic                 r_sat;
    logic                 r_ovf;

    logic signed [AW-1:0] w_prod_sx;
    logic signed [AW-1:0] w_im_sum;
    sat_rnd_t             w_re_sr;
    sat_rnd_t             w_im_sr;
    cplx_t                w_din;
    cplx_t                w_dout;
    logic                 w_push;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_drop;

    assign w_prod_sx = AW'(i_prod_in);
    assign w_im_sum  = r_acc_im + w_prod_sx;
    assign w_re_sr   = sat_round(r_acc_re);
    assign w_im_sr   = sat_round(w_im_sum);
    assign w_din     = '{re: w_re_sr.val, im: w_im_sr.val};

    // The multiplier cannot stall, so a BC strobe always pushes; clr wins.
    assign w_push = i_prod_valid && !i_clr && (r_phase == PH_BC);
    assign w_drop = w_push && w_full && !i_y_ready;

    always_comb begin
        w_phase_nxt = PH_AC;
        unique case (r_phase)
            PH_AC: w_phase_nxt = PH_BD;
            PH_BD: w_phase_nxt = PH_AD;
            PH_AD: w_phase_nxt = PH_BC;
            PH_BC: w_phase_nxt = PH_AC;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_phase  <= PH_AC;
            r_acc_re <= '0;
            r_acc_im <= '0;
            r_sat    <= 1'b0;
            r_ovf    <= 1'b0;
        end else if (i_clr) begin
            r_phase  <= PH_AC;
            r_acc_re <= '0;
            r_acc_im <= '0;
            r_sat    <= 1'b0;
            r_ovf    <= 1'b0;
        end else if (i_prod_valid) begin
            r_phase <= w_phase_nxt;
            unique case (r_phase)
                PH_AC: r_acc_re <= w_prod_sx;
                PH_BD: r_acc_re <= r_acc_re - w_prod_sx;
                PH_AD: r_acc_im <= w_prod_sx;
                PH_BC: begin
                    if (w_re_sr.clamp || w_im_sr.clamp) r_sat <= 1'b1;
                    if (w_drop) r_ovf <= 1'b1;
                end
            endcase
        end
    end

    cplx_fifo #(
        .W     (2 * DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_clr   (i_clr),
        .i_push  (w_push),
        .i_din   (w_din),
        .i_ready (i_y_ready),
        .o_dout  (w_dout),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign o_y_re    = w_dout.re;
    assign o_y_im    = w_dout.im;
    assign o_y_valid = !w_empty;
    assign o_phase   = r_phase;
    assign o_sat     = r_sat;
    assign o_ovf     = r_ovf;

endmodule

// File: tb/tb_twiddle_prod_combine.sv
// Bench for twiddle_prod_combine: directed vector table, multi-cycle FIFO and
// reset/clear sequences, then random quads against a queue-based model.
module tb_twiddle_prod_combine;

    logic               clk;
    logic               reset;
    logic               clr;
    logic signed [31:0] prod_in;
    logic               prod_valid;
    logic        [15:0] y_re;
    logic        [15:0] y_im;
    logic               y_valid;
    logic               y_ready;
    logic        [1:0]  phase;
    logic               sat;
    logic               ovf;

    int total = 0;
    int bad   = 0;

    twiddle_prod_combine #(.DEPTH(2)) dut (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_clr        (clr),
        .i_prod_in    (prod_in),
        .i_prod_valid (prod_valid),
        .o_y_re       (y_re),
        .o_y_im       (y_im),
        .o_y_valid    (y_valid),
        .i_y_ready    (y_ready),
        .o_phase      (phase),
        .o_sat        (sat),
        .o_ovf        (ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] p [4];
        logic [15:0] re;
        logic [15:0] im;
        logic        s;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are read on the next one.
    task automatic step(input logic v, input logic [31:0] p, input logic rdy, input logic c);
        prod_valid = v;
        prod_in    = p;
        y_ready    = rdy;
        clr        = c;
        @(negedge clk);
        prod_valid = 1'b0;
        clr        = 1'b0;
    endtask

    task automatic quad(input logic [31:0] p0, p1, p2, p3, input logic rdy);
        step(1'b1, p0, rdy, 1'b0);
        step(1'b1, p1, rdy, 1'b0);
        step(1'b1, p2, rdy, 1'b0);
        step(1'b1, p3, rdy, 1'b0);
    endtask

    task automatic chk_head(input string nm, input logic [15:0] re, input logic [15:0] im);
        chk({nm, "_vld"}, longint'(y_valid), 1);
        chk({nm, "_re"}, longint'(y_re), longint'(re));
        chk({nm, "_im"}, longint'(y_im), longint'(im));
    endtask

    // Floor((x + 1/2 LSB) / 2^15) with explicit floor for negatives.
    function automatic longint round_q15(input longint x);
        longint n, q;
        n = x + 64'sd16384;
        q = n / 64'sd32768;
        if (n < 0 && (n % 64'sd32768) != 0) q = q - 1;
        return q;
    endfunction

    function automatic longint rnd_prod();
        case ($urandom_range(7, 0))
            0: return 64'sd1073741824;
            1: return -64'sd1073741824;
            2: return 64'sd0;
            3: return ($urandom_range(1, 0) != 0) ? 64'sd16384 : -64'sd16384;
            default: return longint'($urandom_range(32'h8000_0000, 0)) - 64'sd1073741824;
        endcase
    endfunction

    longint q_re [$];
    longint q_im [$];
    longint qd [4];
    int     mph;
    bit     msat;
    bit     movf;

    initial begin
        clk = 0; reset = 0; clr = 0; prod_in = '0; prod_valid = 0; y_ready = 0;

        vecs[0] = '{'{32'h3FFF0001, 32'h0, 32'h0, 32'h0}, 16'h7FFE, 16'h0000, 1'b0};
        vecs[1] = '{'{32'h40000000, 32'hC0000000, 32'h0, 32'h00008000}, 16'h7FFF, 16'h0001, 1'b1};
        vecs[2] = '{'{32'hFFFF4000, 32'h0, 32'h0, 32'h0}, 16'hFFFF, 16'h0000, 1'b0};
        vecs[3] = '{'{32'h0, 32'h0, 32'hC0000000, 32'hC0000000}, 16'h0000, 16'h8000, 1'b1};
        vecs[4] = '{'{32'h00004000, 32'h0, 32'hFFFFC000, 32'h0}, 16'h0001, 16'h0000, 1'b0};
        vecs[5] = '{'{32'h00010000, 32'h00018000, 32'h12345678, 32'h0}, 16'hFFFF, 16'h2469, 1'b0};
        vecs[6] = '{'{32'h3FFFC000, 32'h0, 32'h0, 32'hC0000000}, 16'h7FFF, 16'h8000, 1'b1};
        vecs[7] = '{'{32'h3FFFBFFF, 32'h0, 32'h0, 32'h0}, 16'h7FFF, 16'h0000, 1'b0};

        @(negedge clk);
        @(negedge clk);
        chk("rst_phase", longint'(phase), 0);
        chk("rst_vld", longint'(y_valid), 0);
        chk("rst_re", longint'(y_re), 0);
        chk("rst_im", longint'(y_im), 0);
        chk("rst_sat", longint'(sat), 0);
        chk("rst_ovf", longint'(ovf), 0);
        reset = 1;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            step(1'b0, 32'h0, 1'b1, 1'b1);
            step(1'b1, vecs[i].p[0], 1'b1, 1'b0);
            step(1'b1, vecs[i].p[1], 1'b1, 1'b0);
            step(1'b1, vecs[i].p[2], 1'b1, 1'b0);
            chk($sformatf("v%0d_pre_vld", i), longint'(y_valid), 0);
            step(1'b1, vecs[i].p[3], 1'b1, 1'b0);
            chk_head($sformatf("v%0d", i), vecs[i].re, vecs[i].im);
            chk($sformatf("v%0d_sat", i), longint'(sat), longint'(vecs[i].s));
            chk($sformatf("v%0d_phase", i), longint'(phase), 0);
            chk($sformatf("v%0d_ovf", i), longint'(ovf), 0);
            step(1'b0, 32'h0, 1'b1, 1'b0);
            chk($sformatf("v%0d_pop_vld", i), longint'(y_valid), 0);
        end

        // Backpressure: two held in order, third dropped.
        step(1'b0, 32'h0, 1'b0, 1'b1);
        quad(32'h00008000, 32'h0, 32'h0, 32'h00010000, 1'b0);
        quad(32'h00018000, 32'h0, 32'h0, 32'h00020000, 1'b0);
        chk("bp_ovf_pre", longint'(ovf), 0);
        quad(32'h00028000, 32'h0, 32'h0, 32'h00030000, 1'b0);
        chk("bp_ovf", longint'(ovf), 1);
        chk_head("bp_h0", 16'h0001, 16'h0002);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        chk_head("bp_h1", 16'h0003, 16'h0004);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        chk("bp_empty", longint'(y_valid), 0);

        // Reset mid-quad throws away the partial sum and sticky state.
        step(1'b0, 32'h0, 1'b0, 1'b1);
        quad(32'h40000000, 32'hC0000000, 32'h0, 32'h00008000, 1'b0);
        step(1'b1, 32'h11111111, 1'b0, 1'b0);
        step(1'b1, 32'h22222222, 1'b0, 1'b0);
        chk("mr_phase_pre", longint'(phase), 2);
        chk("mr_sat_pre", longint'(sat), 1);
        reset = 0;
        #1;
        chk("mr_phase", longint'(phase), 0);
        chk("mr_vld", longint'(y_valid), 0);
        chk("mr_sat", longint'(sat), 0);
        chk("mr_ovf", longint'(ovf), 0);
        @(negedge clk);
        reset = 1;
        quad(32'h40000000, 32'h0, 32'h0, 32'h40000000, 1'b1);
        chk_head("mr_q", 16'h7FFF, 16'h7FFF);
        chk("mr_q_sat", longint'(sat), 1);

        // Full FIFO: pop and push land in the same cycle.
        step(1'b0, 32'h0, 1'b0, 1'b1);
        chk("ff_clr_sat", longint'(sat), 0);
        chk("ff_clr_vld", longint'(y_valid), 0);
        quad(32'h00038000, 32'h0, 32'h0, 32'h00040000, 1'b0);
        quad(32'h00048000, 32'h0, 32'h0, 32'h00050000, 1'b0);
        step(1'b1, 32'h00058000, 1'b0, 1'b0);
        step(1'b1, 32'h0, 1'b0, 1'b0);
        step(1'b1, 32'h0, 1'b0, 1'b0);
        step(1'b1, 32'h00060000, 1'b1, 1'b0);
        chk_head("ff_h0", 16'h0009, 16'h000A);
        chk("ff_ovf", longint'(ovf), 0);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        chk_head("ff_h1", 16'h000B, 16'h000C);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        chk("ff_empty", longint'(y_valid), 0);

        // clr together with a strobe: strobe discarded, next one is AC.
        step(1'b1, 32'h7FFF0000, 1'b1, 1'b0);
        chk("cl_phase_pre", longint'(phase), 1);
        step(1'b1, 32'h12345678, 1'b1, 1'b1);
        chk("cl_phase", longint'(phase), 0);
        quad(32'h00018000, 32'h0, 32'h0, 32'h00010000, 1'b0);
        chk_head("cl_q", 16'h0003, 16'h0002);

        // Random quads with random gaps and backpressure.
        step(1'b0, 32'h0, 1'b0, 1'b1);
        q_re.delete();
        q_im.delete();
        mph = 0; msat = 0; movf = 0;
        for (int n = 0; n < 1200; n++) begin
            bit     v;
            bit     rdy;
            longint p;
            v   = ($urandom_range(3, 0) != 0);
            rdy = ($urandom_range(99, 0) < ((n < 600) ? 70 : 15));
            p   = rnd_prod();
            step(v, 32'(p), rdy, 1'b0);
            if (q_re.size() > 0 && rdy) begin
                void'(q_re.pop_front());
                void'(q_im.pop_front());
            end
            if (v) begin
                qd[mph] = p;
                if (mph == 3) begin
                    longint r, im;
                    r  = round_q15(qd[0] - qd[1]);
                    im = round_q15(qd[2] + qd[3]);
                    if (r > 32767 || r < -32768 || im > 32767 || im < -32768) msat = 1;
                    r  = (r > 32767) ? 32767 : ((r < -32768) ? -32768 : r);
                    im = (im > 32767) ? 32767 : ((im < -32768) ? -32768 : im);
                    if (q_re.size() < 2) begin
                        q_re.push_back(r);
                        q_im.push_back(im);
                    end else begin
                        movf = 1;
                    end
                end
                mph = (mph + 1) % 4;
            end
            chk("rnd_vld", longint'(y_valid), longint'(q_re.size() > 0));
            chk("rnd_phase", longint'(phase), longint'(mph));
            chk("rnd_sat", longint'(sat), longint'(msat));
            chk("rnd_ovf", longint'(ovf), longint'(movf));
            if (q_re.size() > 0) begin
                chk("rnd_re", longint'(y_re), q_re[0] & 64'hFFFF);
                chk("rnd_im", longint'(y_im), q_im[0] & 64'hFFFF);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
